// File: rtl/rc_int_pkg.sv
// Shared constants and types for the interrupt-channel FIFO bank.
package rc_int_pkg;

  localparam int unsigned LevelW   = 3;
  localparam int unsigned MaxDepth = 7;

  typedef logic [LevelW-1:0] rc_int_level_t;

endpackage

// File: rtl/rc_int_fifo.sv
// Single-channel FIFO: registered level, modulo-Depth pointers, no bypass paths.
// Storage is not reset; only pointers and level are cleared.
module rc_int_fifo
  import rc_int_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DataW-1:0]     push_data,
  input  logic                 pop,
  output logic                 ready,
  output rc_int_level_t        level,
  output logic [DataW-1:0]     head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam rc_int_level_t   DepthLvl = LevelW'(Depth);

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  rc_int_level_t    level_q, level_d;
  logic             do_push, do_pop;

  // Accept/pop qualification and next-state for pointers and level
  always_comb begin
    do_push  = push && (level_q < DepthLvl);
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign ready = (level_q < DepthLvl);
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rc_int_fifo_bank.sv
// Bank of per-channel interrupt FIFOs drained through one round-robin pop port.
// A grant that is presented but not accepted is held until the consumer takes it.
module rc_int_fifo_bank
  import rc_int_pkg::*;
#(
  parameter int unsigned NumRcInt = 8,
  parameter int unsigned DataW    = 16,
  parameter int unsigned Depth    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumRcInt-1:0]                wr_valid,
  input  logic [NumRcInt-1:0][DataW-1:0]     wr_data,
  output logic [NumRcInt-1:0]                wr_ready,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [DataW-1:0]                   rd_data,
  output logic [$clog2(NumRcInt)-1:0]        rd_chan,
  output logic [NumRcInt-1:0][2:0]           amf_rc_int_fifo_level
);

  localparam int unsigned ChanW = $clog2(NumRcInt);
  localparam int unsigned SumW  = ChanW + 1;
  localparam logic [ChanW-1:0] LastChan = ChanW'(NumRcInt - 1);

  logic [NumRcInt-1:0]            nonempty;
  logic [NumRcInt-1:0]            pop_vec;
  logic [NumRcInt-1:0][DataW-1:0] head;

  logic [ChanW-1:0] rr_ptr_q, rr_ptr_d;
  logic             hold_vld_q, hold_vld_d;
  logic [ChanW-1:0] hold_chan_q, hold_chan_d;

  logic [ChanW-1:0] search_chan;
  logic [ChanW-1:0] grant_chan;
  logic [SumW-1:0]  cand;
  logic             found;
  logic             pop;

  for (genvar i = 0; i < NumRcInt; i++) begin : g_chan
    rc_int_fifo #(
      .Depth (Depth),
      .DataW (DataW)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_valid[i]),
      .push_data (wr_data[i]),
      .pop       (pop_vec[i]),
      .ready     (wr_ready[i]),
      .level     (amf_rc_int_fifo_level[i]),
      .head      (head[i])
    );
    assign nonempty[i] = (amf_rc_int_fifo_level[i] != '0);
  end

  // First non-empty channel at or after rr_ptr, wrapping modulo NumRcInt
  always_comb begin
    found       = 1'b0;
    search_chan = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NumRcInt; k++) begin
      cand = {1'b0, rr_ptr_q} + SumW'(k);
      if (cand >= SumW'(NumRcInt)) begin
        cand = cand - SumW'(NumRcInt);
      end
      if (!found && nonempty[cand[ChanW-1:0]]) begin
        found       = 1'b1;
        search_chan = cand[ChanW-1:0];
      end
    end
  end

  // Pop port, grant hold and round-robin pointer update
  always_comb begin
    rd_valid    = |nonempty;
    grant_chan  = hold_vld_q ? hold_chan_q : search_chan;
    rd_chan     = rd_valid ? grant_chan : '0;
    rd_data     = rd_valid ? head[grant_chan] : '0;
    pop         = rd_valid && rd_ready;
    pop_vec     = '0;
    if (pop) begin
      pop_vec[grant_chan] = 1'b1;
    end
    hold_vld_d  = rd_valid && !rd_ready;
    hold_chan_d = grant_chan;
    rr_ptr_d    = rr_ptr_q;
    if (pop) begin
      rr_ptr_d = (grant_chan == LastChan) ? '0 : grant_chan + ChanW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      hold_vld_q  <= 1'b0;
      hold_chan_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      hold_vld_q  <= hold_vld_d;
      hold_chan_q <= hold_chan_d;
    end
  end

endmodule

// File: tb/tb_rc_int_fifo_bank.sv
// Directed scenarios for rc_int_fifo_bank; pops are checked against a scoreboard queue.
module tb_rc_int_fifo_bank;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [DW-1:0] data;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N-1:0]             wr_valid;
  logic [N-1:0][DW-1:0]     wr_data;
  logic [N-1:0]             wr_ready;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [DW-1:0]            rd_data;
  logic [CW-1:0]            rd_chan;
  logic [N-1:0][2:0]        lvl;

  exp_t exp_q[$];
  exp_t exp_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  rc_int_fifo_bank #(
    .NumRcInt (N),
    .DataW    (DW),
    .Depth    (D)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .wr_valid              (wr_valid),
    .wr_data               (wr_data),
    .wr_ready              (wr_ready),
    .rd_valid              (rd_valid),
    .rd_ready              (rd_ready),
    .rd_data               (rd_data),
    .rd_chan               (rd_chan),
    .amf_rc_int_fifo_level (lvl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_pop(input int ch, input logic [DW-1:0] d);
    exp_q.push_back('{chan: CW'(ch), data: d});
  endtask

  task automatic push1(input int ch, input logic [DW-1:0] d);
    wr_valid     = '0;
    wr_valid[ch] = 1'b1;
    wr_data[ch]  = d;
    tick();
    wr_valid     = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    wr_valid = '0;
    for (int i = 0; i < cycles; i++) tick();
    rst      = 1'b0;
  endtask

  task automatic drain(input string name);
    int cnt;
    cnt      = 0;
    rd_ready = 1'b1;
    while (rd_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check(name, 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got chan=%0d data=%0h, expected no pop", rd_chan, rd_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (rd_chan !== exp_e.chan || rd_data !== exp_e.data) begin
          n_fail++;
          $display("FAIL pop_order: got chan=%0d data=%0h, expected chan=%0d data=%0h",
                   rd_chan, rd_data, exp_e.chan, exp_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    wr_valid = '0;
    wr_data  = '0;
    rd_ready = 1'b0;

    // Reset state
    do_reset(2);
    check("rst_level", 32'(lvl), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'hFF);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_chan", 32'(rd_chan), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);

    // Fill channel 3 to full, overflow push ignored, drain in order
    for (int i = 0; i < 4; i++) begin
      push1(3, 16'hA0 + 16'(i));
      expect_pop(3, 16'hA0 + 16'(i));
    end
    check("fill_level3", 32'(lvl[3]), 32'd4);
    check("fill_wr_ready3", 32'(wr_ready[3]), 32'd0);
    check("fill_wr_ready_vec", 32'(wr_ready), 32'hF7);
    check("fill_rd_chan", 32'(rd_chan), 32'd3);
    push1(3, 16'hA4);
    check("overflow_level3", 32'(lvl[3]), 32'd4);
    drain("fill_drain");
    check("fill_empty_level", 32'(lvl), 32'd0);

    // Round robin over channels 1,5,6 with a refill of channel 1
    do_reset(1);
    wr_valid    = 8'b0110_0010;
    wr_data[1]  = 16'h0111;
    wr_data[5]  = 16'h0555;
    wr_data[6]  = 16'h0666;
    tick();
    wr_valid    = '0;
    expect_pop(1, 16'h0111);
    expect_pop(5, 16'h0555);
    expect_pop(6, 16'h0666);
    expect_pop(1, 16'h011B);
    check("rr_first_chan", 32'(rd_chan), 32'd1);
    rd_ready    = 1'b1;
    wr_valid[1] = 1'b1;
    wr_data[1]  = 16'h011B;
    tick();
    wr_valid    = '0;
    check("rr_after_pop_chan", 32'(rd_chan), 32'd5);
    drain("rr_drain");

    // Grant hold: channel 5 presented, channel 2 must not steal it
    push1(5, 16'h0055);
    check("hold_initial_chan", 32'(rd_chan), 32'd5);
    push1(2, 16'h0022);
    check("hold_chan_a", 32'(rd_chan), 32'd5);
    check("hold_data_a", 32'(rd_data), 32'h0055);
    tick();
    check("hold_chan_b", 32'(rd_chan), 32'd5);
    check("hold_level2", 32'(lvl[2]), 32'd1);
    expect_pop(5, 16'h0055);
    expect_pop(2, 16'h0022);
    drain("hold_drain");

    // Simultaneous push and pop on channel 0, enough to wrap pointers
    push1(0, 16'h00C0);
    push1(0, 16'h00C1);
    expect_pop(0, 16'h00C0);
    expect_pop(0, 16'h00C1);
    check("simul_start_level", 32'(lvl[0]), 32'd2);
    for (int i = 0; i < 10; i++) begin
      wr_valid[0] = 1'b1;
      wr_data[0]  = 16'h00C2 + 16'(i);
      rd_ready    = 1'b1;
      expect_pop(0, 16'h00C2 + 16'(i));
      tick();
      check("simul_level", 32'(lvl[0]), 32'd2);
    end
    wr_valid = '0;
    drain("simul_drain");

    // Mid-operation reset discards everything, including a coincident pop
    rd_ready    = 1'b0;
    wr_valid    = 8'b1001_0010;
    wr_data[1]  = 16'h0D10;
    wr_data[4]  = 16'h0D40;
    wr_data[7]  = 16'h0D70;
    tick();
    wr_valid    = 8'b1000_0010;
    wr_data[1]  = 16'h0D11;
    wr_data[7]  = 16'h0D71;
    tick();
    wr_valid    = 8'b0000_0010;
    wr_data[1]  = 16'h0D12;
    tick();
    wr_valid    = '0;
    check("mid_level1", 32'(lvl[1]), 32'd3);
    check("mid_level4", 32'(lvl[4]), 32'd1);
    check("mid_level7", 32'(lvl[7]), 32'd2);
    rd_ready = 1'b1;
    do_reset(1);
    check("mid_rst_level", 32'(lvl), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_wr_ready", 32'(wr_ready), 32'hFF);
    for (int i = 0; i < 3; i++) tick();
    check("mid_idle_rd_valid", 32'(rd_valid), 32'd0);
    expect_pop(7, 16'h00E7);
    push1(7, 16'h00E7);
    check("mid_fresh_chan", 32'(rd_chan), 32'd7);
    check("mid_fresh_data", 32'(rd_data), 32'h00E7);
    drain("mid_drain");

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
